// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the conv2d host-side frame store.
package conv_pkg;

  localparam int IMG_W  = 50;
  localparam int IMG_H  = 50;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int PIX_W  = 12;
  localparam int ADDR_W = 17;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/frame_ram.sv
// Frame buffer: one synchronous write port, one asynchronous read port.
// Addresses at or beyond DEPTH never write and read back as zero.
module frame_ram #(
  parameter int DEPTH  = 2500,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_in_range;
  logic              rd_in_range;

  assign wr_in_range = (wr_addr_i < ADDR_W'(DEPTH));
  assign rd_in_range = (rd_addr_i < ADDR_W'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (we_i && wr_in_range) begin
      mem_q[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_in_range ? mem_q[rd_addr_i[IDX_W-1:0]] : '0;

endmodule

// File: rtl/conv_frame_host.sv
// Host-side responder for the conv2d engine: loads an input frame, kicks the
// engine, serves its reads, captures its writes, then streams the result out.
import conv_pkg::*;

module conv_frame_host #(
  parameter int IMG_W  = conv_pkg::IMG_W,
  parameter int IMG_H  = conv_pkg::IMG_H,
  parameter int PIX_W  = conv_pkg::PIX_W,
  parameter int ADDR_W = conv_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  output logic              conv_start,
  input  logic [ADDR_W-1:0] conv_rd_addr,
  output logic [PIX_W-1:0]  conv_d_in,
  input  logic [ADDR_W-1:0] conv_wr_addr,
  input  logic [PIX_W-1:0]  conv_d_out,
  input  logic              conv_we,
  input  logic              conv_ready,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_last,
  output logic              busy,
  output logic              err
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               conv_ready_q;
  logic               err_q, err_d;
  logic [PIX_W-1:0]   m_data_q, m_data_d;
  logic               m_last_q, m_last_d;

  logic               in_we;
  logic               run_we;
  logic               wr_in_range;
  logic               ready_rise;
  logic [ADDR_W-1:0]  out_rd_addr;
  logic [PIX_W-1:0]   out_rd_data;

  assign in_we       = (state_q == ST_LOAD) && s_valid;
  assign run_we      = (state_q == ST_RUN) && conv_we;
  assign wr_in_range = (conv_wr_addr < ADDR_W'(NPIX));
  assign ready_rise  = conv_ready && !conv_ready_q;

  // The output buffer is read one pixel ahead so m_data can be registered:
  // pixel 0 while waiting for the engine, drain_cnt+1 while draining.
  assign out_rd_addr = (state_q == ST_DRAIN) ? (ADDR_W'(drain_cnt_q) + ADDR_W'(1)) : '0;

  frame_ram #(.DEPTH(NPIX), .DATA_W(PIX_W), .ADDR_W(ADDR_W)) u_in_ram (
    .clk_i     (clk),
    .we_i      (in_we),
    .wr_addr_i (ADDR_W'(load_cnt_q)),
    .wr_data_i (s_data),
    .rd_addr_i (conv_rd_addr),
    .rd_data_o (conv_d_in)
  );

  frame_ram #(.DEPTH(NPIX), .DATA_W(PIX_W), .ADDR_W(ADDR_W)) u_out_ram (
    .clk_i     (clk),
    .we_i      (run_we && wr_in_range),
    .wr_addr_i (conv_wr_addr),
    .wr_data_i (conv_d_out),
    .rd_addr_i (out_rd_addr),
    .rd_data_o (out_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    err_d       = err_q | (run_we && !wr_in_range);
    case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          if (load_cnt_q == CNT_W'(NPIX - 1)) begin
            load_cnt_d = '0;
            state_d    = ST_START;
          end else begin
            load_cnt_d = load_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (ready_rise) begin
          state_d  = ST_DRAIN;
          m_data_d = out_rd_data;
          m_last_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          m_data_d = out_rd_data;
          if (m_last_q) begin
            state_d     = ST_LOAD;
            drain_cnt_d = '0;
            m_last_d    = 1'b0;
          end else begin
            drain_cnt_d = drain_cnt_q + CNT_W'(1);
            m_last_d    = (drain_cnt_q == CNT_W'(NPIX - 2));
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      load_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      conv_ready_q <= 1'b0;
      err_q        <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      conv_ready_q <= conv_ready;
      err_q        <= err_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
    end
  end

  assign s_ready    = (state_q == ST_LOAD);
  assign conv_start = (state_q == ST_START);
  assign busy       = (state_q != ST_LOAD);
  assign m_valid    = (state_q == ST_DRAIN);
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign err        = err_q;

endmodule
